div32_seq: RTL
==============

// Module: div32_seq
// PURPOSE
//  Iterative 32-bit integer divider; the subtract/shift counterpart to the CPU's ripple-carry adder datapath.
//  Restoring division, one quotient bit per clock, RISC-V DIV/DIVU/REM/REMU semantics.
//  Sits beside the ALU in execute; the core stalls on busy and captures results on done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (iteration count = WIDTH)
// PORTS
//  clk          in   1      system clock, rising edge
//  n_rst        in   1      synchronous active-low reset
//  start        in   1      request; sampled only when busy=0
//  is_signed    in   1      1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU
//  dividend     in   WIDTH  numerator, sampled with start
//  divisor      in   WIDTH  denominator, sampled with start
//  busy         out  1      operation in progress; start ignored
//  done         out  1      one-cycle pulse: quotient/remainder valid
//  quotient     out  WIDTH  result, held until next accepted start
//  remainder    out  WIDTH  result, held until next accepted start
//  div_by_zero  out  1      flag for the last completed op, held with results
// BEHAVIOUR
//  Cycle n = interval after rising edge n. Start accepted at edge k when start=1 and busy=0.
//  Reset (n_rst=0 at an edge): state IDLE; busy/done/quotient/remainder/div_by_zero = 0.
//   Reset has priority over all other events, including mid-CALC; an aborted op produces no done.
//  FSM: IDLE -> CALC -> FINISH -> IDLE. Special cases go IDLE -> FINISH directly.
//   IDLE: busy=0. On accept, latch operands and is_signed.
//    divisor==0 or (is_signed and dividend==MIN_NEG and divisor==all-ones) -> FINISH.
//    Otherwise -> CALC with iteration counter = WIDTH.
//   CALC: busy=1. Operate on magnitudes |dividend| and |divisor|; unsigned mode uses raw values.
//    Each cycle: shift {rem,quo} left 1; trial = rem - divisor as rem + ~divisor + 1.
//    Carry-out 1 (no borrow): rem = trial and quo[0] = 1; else rem unchanged and quo[0] = 0.
//    Counter decrements; counter reaching 0 moves to FINISH.
//   FINISH: busy=0, done=1 for exactly one cycle; outputs registered at this edge.
//    Signed sign fix: quotient negated if dividend and divisor signs differ;
//    remainder takes dividend's sign.
//    Divide-by-zero: quotient = all-ones, remainder = dividend, div_by_zero = 1.
//    Signed overflow: quotient = MIN_NEG, remainder = 0, div_by_zero = 0.
//    start=1 during FINISH is accepted (back-to-back); next state per IDLE rules.
//  Latency: normal op done in cycle k+WIDTH+1; special case done in cycle k+1.
//  start while busy=1 is ignored with no side effects; operand changes during CALC have no effect.
//  Results and div_by_zero change only at FINISH or reset.
//  Arithmetic: internal remainder is WIDTH+1 bits so the trial subtract never overflows.
//   Negation is ~x+1 mod 2^WIDTH.
// TESTING
//  1. Unsigned 100/7, start at edge 0 -> done in cycle 33 only;
//     q=14, r=2, div_by_zero=0; busy=1 in cycles 1..32.
//  2. Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF;
//     unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  3. 5/0, both modes -> done in cycle 1, q=0xFFFFFFFF, r=5, div_by_zero=1, busy never 1.
//  4. Signed 0x80000000/0xFFFFFFFF -> done in cycle 1, q=0x80000000, r=0, div_by_zero=0;
//     same operands unsigned -> q=0, r=0x80000000 after 33 cycles.
//  5. Start 1000/3, n_rst=0 at edge 10 -> busy=0 and all outputs 0 from cycle 10; no done pulse;
//     new op afterwards computes correctly.
//  6. Start pulsed at edge 5 during CALC -> ignored, first result intact;
//     start held on the done cycle -> second op accepted, done 33 cycles later.

Source files
------------

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Implements RISC-V DIV/DIVU/REM/REMU results, including the
// divide-by-zero and signed-overflow special cases, which bypass
// the iteration and complete on the next clock.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;       // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q;       // divisor magnitude
  logic [WIDTH-1:0] dvd_q;       // raw dividend, returned on divide-by-zero
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dbz_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             div_by_zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic             is_zero_d;
  logic             is_ovf_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             carry;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic             unused_trial_msb;

  // Request acceptance and operand preparation (magnitudes, special cases).
  always_comb begin
    // NOTE: every signal gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    accept    = start && !busy_q && (state_q == IDLE || state_q == FINISH);
    dvd_mag_d = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag_d = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
    is_zero_d = (divisor == '0);
    is_ovf_d  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  end

  // One restoring step: shift, trial subtract via add-with-carry, keep or restore.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
    carry   = trial[WIDTH+1];
    rem_d   = carry ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], carry};
  end

  // A successful trial always leaves a remainder below the divisor, so bit WIDTH is zero.
  assign unused_trial_msb = trial[WIDTH];

  // Final result selection: special cases first, then sign fix-up of magnitudes.
  always_comb begin
    if (dbz_q) begin
      quotient_d  = '1;
      remainder_d = dvd_q;
    end else if (ovf_q) begin
      quotient_d  = MIN_NEG;
      remainder_d = '0;
    end else begin
      quotient_d  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
      remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end
  end

  // Control FSM with registered outputs and the iteration datapath.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      // NOTE: the datapath registers are reset as well because the result
      // outputs must read zero after reset; this is a handful of flops, not a memory.
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain updates within one edge.
      done_q <= 1'b0;
      case (state_q)
        CALC: begin
          busy_q <= 1'b1;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          quotient_q    <= quotient_d;
          remainder_q   <= remainder_d;
          div_by_zero_q <= dbz_q;
          state_q       <= IDLE;
        end
        default: ;
      endcase
      // A new request overrides the FINISH -> IDLE transition for back-to-back use.
      if (accept) begin
        rem_q     <= '0;
        quo_q     <= dvd_mag_d;
        dvs_q     <= dvs_mag_d;
        dvd_q     <= dividend;
        neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_rem_q <= is_signed && dividend[WIDTH-1];
        dbz_q     <= is_zero_d;
        ovf_q     <= is_ovf_d;
        cnt_q     <= CW'(WIDTH);
        state_q   <= (is_zero_d || is_ovf_d) ? FINISH : CALC;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
